// File: rtl/issue_queue_pkg.sv
// Shared constants for the issue queue block.
//
// Holds the default widths used by the queue and its select sub-module,
// plus a small helper that sizes the occupancy counter.
package issue_queue_pkg;

  localparam int IQ_DEPTH       = 8;
  localparam int IQ_NUM_WB      = 2;
  localparam int IQ_LEN_WORD    = 32;
  localparam int IQ_LEN_TAG     = 6;
  localparam int IQ_LEN_CONTEXT = 4;
  localparam int IQ_LEN_PAYLOAD = 48;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int iq_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address one of depth entries (at least one bit).
  function automatic int iq_index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/issue_queue_iq_select.sv
// Priority picker for the issue queue.
//
// Ports:
//   req   in  WIDTH  per-entry request (bit 0 = highest priority / oldest)
//   grant out WIDTH  one-hot grant of the lowest set request bit
//   idx   out IW     binary index of the granted bit (0 when none)
//   any   out 1      at least one request is set
module iq_select #(
  parameter int WIDTH = 8,
  parameter int IW    = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Isolate the lowest set bit and encode its position.
  always_comb begin
    grant = req & (~req + {{(WIDTH-1){1'b0}}, 1'b1});
    any   = |req;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = idx | (grant[i] ? IW'(i) : {IW{1'b0}});
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered issue queue between rename and the execute units.
//
// Entries 0..count-1 are valid, index 0 is the oldest. Each cycle the
// queue drops issued and squashed entries, shifts the survivors down to
// close the holes, applies writeback wakeups, and appends an accepted
// dispatch after the survivors.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   d_valid/d_ready          dispatch handshake
//   d_payload, d_context     opaque exec info and context of the new op
//   d_rs*_rdy/_tag/_data     source operand state of the new op
//   d_pa_rd                  destination tag of the new op
//   wb_valid/wb_tag/wb_data  NUM_WB flat writeback broadcast ports
//   branch_hazard            squash strobe, hazard_context_info = mask
//   e_valid/e_ready          issue handshake
//   e_payload..e_pa_rd       fields of the entry being offered
//   count                    number of occupied entries
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int NUM_WB      = IQ_NUM_WB,
  parameter int LEN_WORD    = IQ_LEN_WORD,
  parameter int LEN_TAG     = IQ_LEN_TAG,
  parameter int LEN_CONTEXT = IQ_LEN_CONTEXT,
  parameter int LEN_PAYLOAD = IQ_LEN_PAYLOAD,
  parameter int IN_ORDER    = 0,
  localparam int CW = iq_count_width(DEPTH),
  localparam int IW = iq_index_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       d_valid,
  output logic                       d_ready,
  input  logic [LEN_PAYLOAD-1:0]     d_payload,
  input  logic [LEN_CONTEXT-1:0]     d_context,
  input  logic                       d_rs1_rdy,
  input  logic                       d_rs2_rdy,
  input  logic [LEN_TAG-1:0]         d_rs1_tag,
  input  logic [LEN_TAG-1:0]         d_rs2_tag,
  input  logic [LEN_WORD-1:0]        d_rs1_data,
  input  logic [LEN_WORD-1:0]        d_rs2_data,
  input  logic [LEN_TAG-1:0]         d_pa_rd,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*LEN_TAG-1:0]  wb_tag,
  input  logic [NUM_WB*LEN_WORD-1:0] wb_data,
  input  logic                       branch_hazard,
  input  logic [LEN_CONTEXT-1:0]     hazard_context_info,
  output logic                       e_valid,
  input  logic                       e_ready,
  output logic [LEN_PAYLOAD-1:0]     e_payload,
  output logic [LEN_CONTEXT-1:0]     e_context,
  output logic [LEN_WORD-1:0]        e_rs1,
  output logic [LEN_WORD-1:0]        e_rs2,
  output logic [LEN_TAG-1:0]         e_pa_rd,
  output logic [CW-1:0]              count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Lowest matching port wins: scanning from the top down lets the
  // lower ports overwrite the result.
  function automatic logic [LEN_WORD-1:0] pick_wb_data(
    input logic [NUM_WB-1:0]          hit,
    input logic [NUM_WB*LEN_WORD-1:0] data
  );
    logic [LEN_WORD-1:0] r;
    r = '0;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      r = hit[k] ? data[k*LEN_WORD +: LEN_WORD] : r;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- state
  logic [DEPTH-1:0]       valid_r;
  logic [LEN_PAYLOAD-1:0] payload_r  [DEPTH];
  logic [LEN_CONTEXT-1:0] context_r  [DEPTH];
  logic [DEPTH-1:0]       rs1_rdy_r;
  logic [DEPTH-1:0]       rs2_rdy_r;
  logic [LEN_TAG-1:0]     rs1_tag_r  [DEPTH];
  logic [LEN_TAG-1:0]     rs2_tag_r  [DEPTH];
  logic [LEN_WORD-1:0]    rs1_data_r [DEPTH];
  logic [LEN_WORD-1:0]    rs2_data_r [DEPTH];
  logic [LEN_TAG-1:0]     pa_rd_r    [DEPTH];
  logic [CW-1:0]          count_r;

  // --------------------------------------------------------------- wakeup
  logic [DEPTH-1:0][NUM_WB-1:0] hit1_s;
  logic [DEPTH-1:0][NUM_WB-1:0] hit2_s;
  logic [NUM_WB-1:0]            dhit1_s;
  logic [NUM_WB-1:0]            dhit2_s;

  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb_port
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign hit1_s[i][k] = wb_valid[k] && (wb_tag[k*LEN_TAG +: LEN_TAG] == rs1_tag_r[i]);
      assign hit2_s[i][k] = wb_valid[k] && (wb_tag[k*LEN_TAG +: LEN_TAG] == rs2_tag_r[i]);
    end
    assign dhit1_s[k] = wb_valid[k] && (wb_tag[k*LEN_TAG +: LEN_TAG] == d_rs1_tag);
    assign dhit2_s[k] = wb_valid[k] && (wb_tag[k*LEN_TAG +: LEN_TAG] == d_rs2_tag);
  end

  logic [DEPTH-1:0]    w_rdy1_s;
  logic [DEPTH-1:0]    w_rdy2_s;
  logic [LEN_WORD-1:0] w_data1_s [DEPTH];
  logic [LEN_WORD-1:0] w_data2_s [DEPTH];

  // Operand state of each resident entry after this cycle's broadcasts;
  // an operand that is already ready keeps its value.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_rdy1_s[i]  = rs1_rdy_r[i] | (|hit1_s[i]);
      w_rdy2_s[i]  = rs2_rdy_r[i] | (|hit2_s[i]);
      w_data1_s[i] = rs1_rdy_r[i] ? rs1_data_r[i] :
                     ((|hit1_s[i]) ? pick_wb_data(hit1_s[i], wb_data) : rs1_data_r[i]);
      w_data2_s[i] = rs2_rdy_r[i] ? rs2_data_r[i] :
                     ((|hit2_s[i]) ? pick_wb_data(hit2_s[i], wb_data) : rs2_data_r[i]);
    end
  end

  logic                d_w_rdy1_s;
  logic                d_w_rdy2_s;
  logic [LEN_WORD-1:0] d_w_data1_s;
  logic [LEN_WORD-1:0] d_w_data2_s;

  assign d_w_rdy1_s  = d_rs1_rdy | (|dhit1_s);
  assign d_w_rdy2_s  = d_rs2_rdy | (|dhit2_s);
  assign d_w_data1_s = d_rs1_rdy ? d_rs1_data : pick_wb_data(dhit1_s, wb_data);
  assign d_w_data2_s = d_rs2_rdy ? d_rs2_data : pick_wb_data(dhit2_s, wb_data);

  // ---------------------------------------------------------- squash/select
  logic [DEPTH-1:0] squash_s;
  logic [DEPTH-1:0] cand_s;

  // An entry being squashed this cycle must never be offered for issue.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      squash_s[i] = valid_r[i] & branch_hazard & (|(context_r[i] & hazard_context_info));
      cand_s[i]   = valid_r[i] & rs1_rdy_r[i] & rs2_rdy_r[i] & ~squash_s[i];
    end
  end

  logic [DEPTH-1:0] grant_s;
  logic [IW-1:0]    idx_s;
  logic             any_s;

  if (IN_ORDER != 0) begin : g_in_order
    assign grant_s = {{(DEPTH-1){1'b0}}, cand_s[0]};
    assign idx_s   = '0;
    assign any_s   = cand_s[0];
  end else begin : g_out_of_order
    iq_select #(
      .WIDTH (DEPTH),
      .IW    (IW)
    ) u_select (
      .req   (cand_s),
      .grant (grant_s),
      .idx   (idx_s),
      .any   (any_s)
    );
  end

  // Issue port fields come straight from registered entries; zero when idle.
  always_comb begin
    e_valid   = any_s;
    e_payload = any_s ? payload_r[idx_s]  : {LEN_PAYLOAD{1'b0}};
    e_context = any_s ? context_r[idx_s]  : {LEN_CONTEXT{1'b0}};
    e_rs1     = any_s ? rs1_data_r[idx_s] : {LEN_WORD{1'b0}};
    e_rs2     = any_s ? rs2_data_r[idx_s] : {LEN_WORD{1'b0}};
    e_pa_rd   = any_s ? pa_rd_r[idx_s]    : {LEN_TAG{1'b0}};
  end

  // ------------------------------------------------------------ compaction
  logic [DEPTH-1:0] issue_s;
  logic [DEPTH-1:0] keep_s;
  logic [CW-1:0]    pos_s [DEPTH+1];

  assign issue_s = grant_s & {DEPTH{e_valid & e_ready}};
  assign keep_s  = valid_r & ~squash_s & ~issue_s;

  // pos_s[i] = survivors strictly below i = destination slot of entry i;
  // pos_s[DEPTH] is the survivor count and the dispatch insertion slot.
  always_comb begin
    pos_s[0] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos_s[i+1] = pos_s[i] + {{(CW-1){1'b0}}, keep_s[i]};
    end
  end

  logic             d_kill_s;
  logic             d_take_s;
  logic [CW-1:0]    n_count;

  // A dispatch in the squashed context is accepted but not written.
  assign d_ready  = (count_r < DEPTH_C);
  assign d_kill_s = branch_hazard & (|(d_context & hazard_context_info));
  assign d_take_s = d_valid & d_ready & ~d_kill_s;
  assign n_count  = pos_s[DEPTH] + {{(CW-1){1'b0}}, d_take_s};

  logic [DEPTH-1:0][DEPTH-1:0] move_s;   // move_s[j][i]: entry i lands in slot j
  logic [DEPTH-1:0]            ins_s;
  logic [DEPTH-1:0]            n_valid;
  logic [LEN_PAYLOAD-1:0]      n_payload  [DEPTH];
  logic [LEN_CONTEXT-1:0]      n_context  [DEPTH];
  logic [DEPTH-1:0]            n_rs1_rdy;
  logic [DEPTH-1:0]            n_rs2_rdy;
  logic [LEN_TAG-1:0]          n_rs1_tag  [DEPTH];
  logic [LEN_TAG-1:0]          n_rs2_tag  [DEPTH];
  logic [LEN_WORD-1:0]         n_rs1_data [DEPTH];
  logic [LEN_WORD-1:0]         n_rs2_data [DEPTH];
  logic [LEN_TAG-1:0]          n_pa_rd    [DEPTH];

  // Shift survivors into their prefix-count slot (AND-OR mux, at most one
  // source per slot), then overlay the accepted dispatch.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      n_valid[j]    = 1'b0;
      n_payload[j]  = '0;
      n_context[j]  = '0;
      n_rs1_rdy[j]  = 1'b0;
      n_rs2_rdy[j]  = 1'b0;
      n_rs1_tag[j]  = '0;
      n_rs2_tag[j]  = '0;
      n_rs1_data[j] = '0;
      n_rs2_data[j] = '0;
      n_pa_rd[j]    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        move_s[j][i]  = keep_s[i] && (pos_s[i] == CW'(j));
        n_valid[j]    = n_valid[j]   | move_s[j][i];
        n_rs1_rdy[j]  = n_rs1_rdy[j] | (move_s[j][i] & w_rdy1_s[i]);
        n_rs2_rdy[j]  = n_rs2_rdy[j] | (move_s[j][i] & w_rdy2_s[i]);
        n_payload[j]  = n_payload[j]  | ({LEN_PAYLOAD{move_s[j][i]}} & payload_r[i]);
        n_context[j]  = n_context[j]  | ({LEN_CONTEXT{move_s[j][i]}} & context_r[i]);
        n_rs1_tag[j]  = n_rs1_tag[j]  | ({LEN_TAG{move_s[j][i]}}     & rs1_tag_r[i]);
        n_rs2_tag[j]  = n_rs2_tag[j]  | ({LEN_TAG{move_s[j][i]}}     & rs2_tag_r[i]);
        n_rs1_data[j] = n_rs1_data[j] | ({LEN_WORD{move_s[j][i]}}    & w_data1_s[i]);
        n_rs2_data[j] = n_rs2_data[j] | ({LEN_WORD{move_s[j][i]}}    & w_data2_s[i]);
        n_pa_rd[j]    = n_pa_rd[j]    | ({LEN_TAG{move_s[j][i]}}     & pa_rd_r[i]);
      end
      ins_s[j]      = d_take_s && (pos_s[DEPTH] == CW'(j));
      n_valid[j]    = ins_s[j] ? 1'b1        : n_valid[j];
      n_payload[j]  = ins_s[j] ? d_payload   : n_payload[j];
      n_context[j]  = ins_s[j] ? d_context   : n_context[j];
      n_rs1_rdy[j]  = ins_s[j] ? d_w_rdy1_s  : n_rs1_rdy[j];
      n_rs2_rdy[j]  = ins_s[j] ? d_w_rdy2_s  : n_rs2_rdy[j];
      n_rs1_tag[j]  = ins_s[j] ? d_rs1_tag   : n_rs1_tag[j];
      n_rs2_tag[j]  = ins_s[j] ? d_rs2_tag   : n_rs2_tag[j];
      n_rs1_data[j] = ins_s[j] ? d_w_data1_s : n_rs1_data[j];
      n_rs2_data[j] = ins_s[j] ? d_w_data2_s : n_rs2_data[j];
      n_pa_rd[j]    = ins_s[j] ? d_pa_rd     : n_pa_rd[j];
    end
  end

  // Entry storage and occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= '0;
      rs1_rdy_r <= '0;
      rs2_rdy_r <= '0;
      count_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_r[i]  <= '0;
        context_r[i]  <= '0;
        rs1_tag_r[i]  <= '0;
        rs2_tag_r[i]  <= '0;
        rs1_data_r[i] <= '0;
        rs2_data_r[i] <= '0;
        pa_rd_r[i]    <= '0;
      end
    end else begin
      valid_r   <= n_valid;
      rs1_rdy_r <= n_rs1_rdy;
      rs2_rdy_r <= n_rs2_rdy;
      count_r   <= n_count;
      for (int i = 0; i < DEPTH; i++) begin
        payload_r[i]  <= n_payload[i];
        context_r[i]  <= n_context[i];
        rs1_tag_r[i]  <= n_rs1_tag[i];
        rs2_tag_r[i]  <= n_rs2_tag[i];
        rs1_data_r[i] <= n_rs1_data[i];
        rs2_data_r[i] <= n_rs2_data[i];
        pa_rd_r[i]    <= n_pa_rd[i];
      end
    end
  end

  assign count = count_r;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: one out-of-order instance (u_dut) and
// one in-order instance (u_dut_io) share the same stimulus.
module tb_issue_queue;

  logic        clk;
  logic        rst;
  logic        d_valid;
  logic [47:0] d_payload;
  logic [3:0]  d_context;
  logic        d_rs1_rdy, d_rs2_rdy;
  logic [5:0]  d_rs1_tag, d_rs2_tag;
  logic [31:0] d_rs1_data, d_rs2_data;
  logic [5:0]  d_pa_rd;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [63:0] wb_data;
  logic        branch_hazard;
  logic [3:0]  hazard_context_info;
  logic        e_ready;

  logic        d_ready, e_valid;
  logic [47:0] e_payload;
  logic [3:0]  e_context;
  logic [31:0] e_rs1, e_rs2;
  logic [5:0]  e_pa_rd;
  logic [3:0]  count;

  logic        io_d_ready, io_e_valid;
  logic [47:0] io_e_payload;
  logic [3:0]  io_e_context;
  logic [31:0] io_e_rs1, io_e_rs2;
  logic [5:0]  io_e_pa_rd;
  logic [3:0]  io_count;

  int checks   = 0;
  int failures = 0;

  issue_queue #(.IN_ORDER(0)) u_dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_ready(d_ready),
    .d_payload(d_payload), .d_context(d_context),
    .d_rs1_rdy(d_rs1_rdy), .d_rs2_rdy(d_rs2_rdy),
    .d_rs1_tag(d_rs1_tag), .d_rs2_tag(d_rs2_tag),
    .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_pa_rd(d_pa_rd),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .branch_hazard(branch_hazard), .hazard_context_info(hazard_context_info),
    .e_valid(e_valid), .e_ready(e_ready), .e_payload(e_payload),
    .e_context(e_context), .e_rs1(e_rs1), .e_rs2(e_rs2),
    .e_pa_rd(e_pa_rd), .count(count)
  );

  issue_queue #(.IN_ORDER(1)) u_dut_io (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_ready(io_d_ready),
    .d_payload(d_payload), .d_context(d_context),
    .d_rs1_rdy(d_rs1_rdy), .d_rs2_rdy(d_rs2_rdy),
    .d_rs1_tag(d_rs1_tag), .d_rs2_tag(d_rs2_tag),
    .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_pa_rd(d_pa_rd),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .branch_hazard(branch_hazard), .hazard_context_info(hazard_context_info),
    .e_valid(io_e_valid), .e_ready(e_ready), .e_payload(io_e_payload),
    .e_context(io_e_context), .e_rs1(io_e_rs1), .e_rs2(io_e_rs2),
    .e_pa_rd(io_e_pa_rd), .count(io_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    d_valid       = 1'b0;
    wb_valid      = 2'b00;
    branch_hazard = 1'b0;
  endtask

  task automatic disp(input logic [3:0] ctx,
                      input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] v2,
                      input logic [5:0] prd);
    d_valid    = 1'b1;
    d_payload  = {42'h0, prd};
    d_context  = ctx;
    d_rs1_rdy  = r1;
    d_rs1_tag  = t1;
    d_rs1_data = v1;
    d_rs2_rdy  = r2;
    d_rs2_tag  = t2;
    d_rs2_data = v2;
    d_pa_rd    = prd;
  endtask

  initial begin
    rst = 1'b1;
    e_ready = 1'b0;
    d_payload = 48'h0; d_context = 4'h0;
    d_rs1_rdy = 1'b0; d_rs2_rdy = 1'b0;
    d_rs1_tag = 6'd0; d_rs2_tag = 6'd0;
    d_rs1_data = 32'h0; d_rs2_data = 32'h0; d_pa_rd = 6'd0;
    wb_tag = 12'h0; wb_data = 64'h0;
    hazard_context_info = 4'h0;
    clear_in();
    tick(); tick();
    rst = 1'b0;
    settle();

    // Reset state
    chk("rst_count",   64'(count),   64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd1);
    chk("rst_e_valid", 64'(e_valid), 64'd0);
    chk("rst_e_rs1",   64'(e_rs1),   64'd0);

    // Three ready ops issue back-to-back in order 1,2,3
    e_ready = 1'b1;
    disp(4'b0001, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h21, 6'd1);
    settle();
    chk("t1_not_yet_visible", 64'(e_valid), 64'd0);
    tick();
    disp(4'b0001, 1'b1, 6'd0, 32'h12, 1'b1, 6'd0, 32'h22, 6'd2);
    settle();
    chk("t1_issue1_valid", 64'(e_valid), 64'd1);
    chk("t1_issue1_tag",   64'(e_pa_rd), 64'd1);
    chk("t1_issue1_rs1",   64'(e_rs1),   64'h11);
    chk("t1_count1",       64'(count),   64'd1);
    tick();
    disp(4'b0001, 1'b1, 6'd0, 32'h13, 1'b1, 6'd0, 32'h23, 6'd3);
    settle();
    chk("t1_issue2_tag", 64'(e_pa_rd), 64'd2);
    chk("t1_issue2_rs2", 64'(e_rs2),   64'h22);
    tick();
    clear_in();
    settle();
    chk("t1_issue3_tag", 64'(e_pa_rd), 64'd3);
    tick();
    chk("t1_count_end",   64'(count),   64'd0);
    chk("t1_e_valid_end", 64'(e_valid), 64'd0);

    // Fill to DEPTH with unready ops, then wake entry 3
    for (int i = 0; i < 8; i++) begin
      disp(4'b0001, 1'b0, 6'(10 + i), 32'h0, 1'b1, 6'd0, 32'h0, 6'(20 + i));
      tick();
    end
    clear_in();
    settle();
    chk("t2_full_count",   64'(count),   64'd8);
    chk("t2_full_d_ready", 64'(d_ready), 64'd0);
    chk("t2_full_e_valid", 64'(e_valid), 64'd0);
    wb_valid = 2'b01;
    wb_tag   = {6'd0, 6'd13};
    wb_data  = {32'h0, 32'h0000_1234};
    settle();
    chk("t2_wake_same_cycle", 64'(e_valid), 64'd0);
    tick();
    clear_in();
    disp(4'b0001, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd50);
    settle();
    chk("t2_woken_valid",  64'(e_valid), 64'd1);
    chk("t2_woken_tag",    64'(e_pa_rd), 64'd23);
    chk("t2_woken_rs1",    64'(e_rs1),   64'h1234);
    chk("t2_issue_full_d_ready", 64'(d_ready), 64'd0);
    tick();
    clear_in();
    settle();
    chk("t2_after_issue_count",   64'(count),   64'd7);
    chk("t2_after_issue_d_ready", 64'(d_ready), 64'd1);
    chk("t2_after_issue_e_valid", 64'(e_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t2_reset_count", 64'(count), 64'd0);

    // Entry 0 waits on tag 5, entry 1 ready: OoO vs in-order
    e_ready = 1'b0;
    disp(4'b0001, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h0, 6'd30);
    tick();
    disp(4'b0001, 1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 32'h0, 6'd31);
    tick();
    clear_in();
    e_ready = 1'b1;
    settle();
    chk("t3_ooo_valid",  64'(e_valid),    64'd1);
    chk("t3_ooo_tag",    64'(e_pa_rd),    64'd31);
    chk("t3_io_blocked", 64'(io_e_valid), 64'd0);
    tick();
    chk("t3_ooo_count",       64'(count),      64'd1);
    chk("t3_io_count",        64'(io_count),   64'd2);
    chk("t3_ooo_none_ready",  64'(e_valid),    64'd0);
    wb_valid = 2'b01;
    wb_tag   = {6'd0, 6'd5};
    wb_data  = {32'h0, 32'h55};
    settle();
    chk("t3_io_still_blocked", 64'(io_e_valid), 64'd0);
    tick();
    clear_in();
    settle();
    chk("t3_io_head_valid", 64'(io_e_valid), 64'd1);
    chk("t3_io_head_tag",   64'(io_e_pa_rd), 64'd30);
    chk("t3_io_head_rs1",   64'(io_e_rs1),   64'h55);
    chk("t3_ooo_head_tag",  64'(e_pa_rd),    64'd30);
    tick();
    chk("t3_io_second_tag",  64'(io_e_pa_rd), 64'd31);
    chk("t3_io_count_after", 64'(io_count),   64'd1);
    chk("t3_ooo_empty",      64'(count),      64'd0);
    tick();
    chk("t3_io_empty", 64'(io_count), 64'd0);

    // Dispatch captures a same-cycle broadcast on port 1
    disp(4'b0001, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h22, 6'd33);
    wb_valid = 2'b11;
    wb_tag   = {6'd9, 6'd7};
    wb_data  = {32'hDEAD_BEEF, 32'h0000_0001};
    tick();
    clear_in();
    settle();
    chk("t4_valid", 64'(e_valid), 64'd1);
    chk("t4_rs1",   64'(e_rs1),   64'hDEAD_BEEF);
    chk("t4_tag",   64'(e_pa_rd), 64'd33);
    tick();
    chk("t4_count_end", 64'(count), 64'd0);

    // Squash contexts 0001 out of {0001,0010,0001,0100}
    e_ready = 1'b0;
    disp(4'b0001, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd40); tick();
    disp(4'b0010, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd41); tick();
    disp(4'b0001, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd42); tick();
    disp(4'b0100, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd43); tick();
    clear_in();
    settle();
    chk("t5_count4", 64'(count), 64'd4);
    branch_hazard       = 1'b1;
    hazard_context_info = 4'b0001;
    disp(4'b0001, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd44);
    settle();
    chk("t5_squash_skips_head", 64'(e_pa_rd),   64'd41);
    chk("t5_squash_ctx",        64'(e_context), 64'h2);
    tick();
    clear_in();
    settle();
    chk("t5_count2",     64'(count),   64'd2);
    chk("t5_oldest_tag", 64'(e_pa_rd), 64'd41);
    e_ready = 1'b1;
    tick();
    chk("t5_second_tag", 64'(e_pa_rd),   64'd43);
    chk("t5_second_ctx", 64'(e_context), 64'h4);
    chk("t5_count1",     64'(count),     64'd1);
    tick();
    chk("t5_count0", 64'(count), 64'd0);

    // Two ports hit one tag: port 0 wins; then reset mid-stream
    e_ready = 1'b0;
    disp(4'b0001, 1'b1, 6'd0, 32'h3, 1'b0, 6'd12, 32'h0, 6'd45);
    tick();
    clear_in();
    wb_valid = 2'b11;
    wb_tag   = {6'd12, 6'd12};
    wb_data  = {32'h0000_BBBB, 32'h0000_AAAA};
    tick();
    clear_in();
    settle();
    chk("t6_valid",     64'(e_valid), 64'd1);
    chk("t6_port0_win", 64'(e_rs2),   64'hAAAA);
    disp(4'b0001, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd46);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_in();
    settle();
    chk("t6_rst_count",   64'(count),   64'd0);
    chk("t6_rst_e_valid", 64'(e_valid), 64'd0);
    chk("t6_rst_d_ready", 64'(d_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised, age-ordered issue queue that succeeds the fixed-size instruction window between decode/rename and the execute units. Holds up to DEPTH renamed instructions, captures operands from NUM_WB writeback broadcast ports, and issues the oldest fully ready entry through a valid/ready handshake. Branch hazards squash entries whose context matches the hazard mask. An in-order mode restricts issue to the head entry.

## Interface
- DEPTH, 8: entry count, ≥2
- NUM_WB, 2: writeback broadcast ports
- LEN_WORD, 32: operand width
- LEN_TAG, 6: physical register tag width
- LEN_CONTEXT, 4: context one-hot/mask width
- LEN_PAYLOAD, 48: opaque exec info (exec_type, imm, func3/7, io_type)
- IN_ORDER, 0: 1 = only entry 0 may issue

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- d_valid  in  1  dispatch request
- d_ready  out  1  queue can accept
- d_payload  in  LEN_PAYLOAD  exec info
- d_context  in  LEN_CONTEXT  instruction context
- d_rs1_rdy / d_rs2_rdy  in  1 each  operand already valid
- d_rs1_tag / d_rs2_tag  in  LEN_TAG each  source tags
- d_rs1_data / d_rs2_data  in  LEN_WORD each  operand value when ready
- d_pa_rd  in  LEN_TAG  destination tag
- wb_valid  in  NUM_WB  broadcast strobes
- wb_tag  in  NUM_WB*LEN_TAG  flat, port k at [k*LEN_TAG +: LEN_TAG]
- wb_data  in  NUM_WB*LEN_WORD  flat, same packing
- branch_hazard  in  1  squash strobe
- hazard_context_info  in  LEN_CONTEXT  squash mask
- e_valid  out  1  issue request
- e_ready  in  1  execute accepts
- e_payload / e_context / e_rs1 / e_rs2 / e_pa_rd  out  issued entry fields
- count  out  clog2(DEPTH+1)  occupied entries

## Operation
- Entries 0..count-1 are valid. Index order equals age order, with 0 the oldest. The queue compacts every cycle, so there are no holes after the edge.
- Squash: when branch_hazard is high, every valid entry with (context & mask) ≠ 0 is invalidated at the edge. A dispatch whose d_context matches the mask is dropped, even if accepted.
- Wakeup: for each valid entry and operand that is not ready, if any wb_valid[k] has wb_tag[k] equal to the operand tag, the ready bit is set and the data is captured at the edge.
  - If several ports match, the lowest k wins.
  - The same comparison applies to a dispatching instruction, so the broadcast is captured on insertion.
- Select: the candidate is the lowest-index entry with both operands ready that is not being squashed this cycle. With IN_ORDER=1, the only candidate is entry 0.
- e_valid is high when a candidate exists. e_* fields come from registered entry state only.
- Issue completes on e_valid & e_ready. The entry is removed at that edge and the entries above it shift down one place.
- Dispatch completes on d_valid & d_ready. The new entry is written at index (count − issued − squashed_below), after compaction.
- d_ready = (count < DEPTH). There is no same-cycle full-queue bypass.
- Count updates to count + dispatched_kept − issued − squashed. The issued entry is not counted again as squashed.

## Timing
- Reset: count=0, d_ready=1, e_valid=0, all entry valid bits cleared, data outputs 0.
- Dispatch in cycle N means the entry is visible, and can issue, from cycle N+1.
- Wakeup in cycle N means the operand is ready at N+1. The entry can issue at N+1 at the earliest.
- e_valid and e_* are combinational from state plus branch_hazard.
  - If e_valid is dropped by a squash, no handshake occurs.
  - e_valid may deassert without e_ready, and issue is not sticky.
- Full with simultaneous issue: d_ready stays 0 that cycle. The freed slot is usable the next cycle.
- Squash, issue and dispatch may occur in the same cycle. The outcome follows the rules above, with compaction preserving relative age.
- Reset mid-operation discards all entries in one cycle. Inputs in the reset cycle are ignored.

## Structure
- Shared constants in include.vh: LEN_WORD, LEN_PREG_ADDR (LEN_TAG), LEN_CONTEXT, LEN_D_E_INFO (LEN_PAYLOAD). No new typedefs.
- Sub-module iq_select: a DEPTH-wide priority picker producing a one-hot grant, a binary index and an any flag. In IN_ORDER mode it is bypassed.
- Compaction uses per-slot prefix counts of surviving entries to form the shift mux. Wakeup compare logic is generated per entry per port.

## Test plan
- Reset, then dispatch 3 ready instructions (tags 1,2,3) with e_ready=1: issue order is 1,2,3 on consecutive cycles starting the cycle after the first dispatch, and count returns to 0.
- Fill DEPTH=8 with unready ops: d_ready=0 at count=8. Broadcast one wakeup tag: the entry issues and d_ready=1 the cycle after the issue.
- Entry 0 waits on tag 5 and entry 1 is ready:
  - IN_ORDER=0: entry 1 issues first.
  - IN_ORDER=1: nothing issues until wb_tag=5, then issue proceeds in order.
- Dispatch rs1_tag=9 in the same cycle as wb_valid[1] with wb_tag[1]=9, data 0xDEAD_BEEF: the entry issues next cycle with e_rs1=0xDEADBEEF.
- Entries with contexts 0001,0010,0001,0100 and branch_hazard with mask 0001: count goes 4→2, and the survivors keep age order (0010 then 0100).
- Ports 0 and 1 both match one tag with different data: port 0 data is captured. Assert rst mid-stream: count=0 and e_valid=0 next cycle.
